// File: rtl/bp_fe_btb_ctrl.sv
// BTB write-side controller: 2-entry update FIFO, lookup hazard detection and
// optional whole-table invalidate (enabled with `define BP_FE_BTB_CTRL_FLUSH_EN).
module bp_fe_btb_ctrl #(
   parameter int unsigned btb_idx_width_p = 9,
   parameter int unsigned eaddr_width_p   = 64
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       upd_v_i,
   output logic                       upd_ready_o,
   input  logic [btb_idx_width_p-1:0] upd_idx_i,
   input  logic [eaddr_width_p-1:0]   upd_tgt_i,
   input  logic                       lkp_v_i,
   output logic                       lkp_ready_o,
   input  logic [btb_idx_width_p-1:0] lkp_idx_i,
   output logic                       lkp_hazard_o,
   input  logic                       flush_i,
   output logic                       flush_busy_o,
   output logic                       flush_done_o,
   output logic                       btb_w_v_o,
   output logic                       btb_w_inv_o,
   output logic [btb_idx_width_p-1:0] btb_idx_w_o,
   output logic [eaddr_width_p-1:0]   btb_tgt_o,
   output logic                       btb_r_v_o,
   output logic [btb_idx_width_p-1:0] btb_idx_r_o
);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_e;

   state_e                     state_q;
   logic [btb_idx_width_p-1:0] fifo_idx_q [2];
   logic [eaddr_width_p-1:0]   fifo_tgt_q [2];
   logic                       wptr_q, rptr_q, rptr_n;
   logic [1:0]                 cnt_q, cnt_d;
   logic                       fifo_empty, fifo_full, enq, deq;
   logic                       hit_head, hit_tail;

   assign fifo_empty = (cnt_q == 2'd0);
   assign fifo_full  = (cnt_q == 2'd2);
   assign rptr_n     = ~rptr_q;

   // Ready is gated by reset so it reads 0 while reset is held.
   assign upd_ready_o = !reset_i && !fifo_full && (state_q == IDLE);
   assign enq         = upd_v_i && upd_ready_o;
   assign deq         = !fifo_empty && ((state_q == IDLE) || (state_q == DRAIN));
   assign cnt_d       = cnt_q + {1'b0, enq} - {1'b0, deq};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_idx_q[i] <= '0;
            fifo_tgt_q[i] <= '0;
         end
      end else begin
         if (enq) begin
            fifo_idx_q[wptr_q] <= upd_idx_i;
            fifo_tgt_q[wptr_q] <= upd_tgt_i;
            wptr_q             <= ~wptr_q;
         end
         if (deq) rptr_q <= ~rptr_q;
         cnt_q <= cnt_d;
      end
   end

   // The head stays visible to the hazard check in the cycle it is dequeued.
   assign hit_head     = !fifo_empty && (fifo_idx_q[rptr_q] == lkp_idx_i);
   assign hit_tail     = fifo_full && (fifo_idx_q[rptr_n] == lkp_idx_i);
   assign lkp_hazard_o = lkp_v_i && (hit_head || hit_tail);

   assign lkp_ready_o = (state_q != FLUSH);
   assign btb_r_v_o   = lkp_v_i && lkp_ready_o;
   assign btb_idx_r_o = lkp_idx_i;

`ifdef BP_FE_BTB_CTRL_FLUSH_EN
   state_e                     state_d;
   logic [btb_idx_width_p-1:0] flush_cnt_q, flush_cnt_d;
   logic                       done_q, done_d;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // An update accepted alongside the flush must drain first.
            if (flush_i) state_d = (!fifo_empty || enq) ? DRAIN : FLUSH;
         end
         DRAIN: begin
            if (cnt_d == 2'd0) state_d = FLUSH;
         end
         FLUSH: begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == '1) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign flush_busy_o = (state_q != IDLE);
   assign flush_done_o = done_q;
`else
   logic unused_flush;
   assign unused_flush = flush_i;
   assign state_q      = IDLE;
   assign flush_busy_o = 1'b0;
   assign flush_done_o = 1'b0;
`endif

   always_comb begin
      btb_w_v_o   = deq;
      btb_w_inv_o = 1'b0;
      btb_idx_w_o = deq ? fifo_idx_q[rptr_q] : '0;
      btb_tgt_o   = deq ? fifo_tgt_q[rptr_q] : '0;
`ifdef BP_FE_BTB_CTRL_FLUSH_EN
      if (state_q == FLUSH) begin
         btb_w_v_o   = 1'b1;
         btb_w_inv_o = 1'b1;
         btb_idx_w_o = flush_cnt_q;
         btb_tgt_o   = '0;
      end
`endif
   end

endmodule

// File: tb/tb_bp_fe_btb_ctrl.sv
// Directed bench for bp_fe_btb_ctrl with an 8-entry BTB; flush scenarios run
// when BP_FE_BTB_CTRL_FLUSH_EN is defined, otherwise flush_i must be ignored.
module tb_bp_fe_btb_ctrl;

   localparam int unsigned IW = 3;
   localparam int unsigned AW = 64;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          upd_v_i, upd_ready_o;
   logic [IW-1:0] upd_idx_i;
   logic [AW-1:0] upd_tgt_i;
   logic          lkp_v_i, lkp_ready_o, lkp_hazard_o;
   logic [IW-1:0] lkp_idx_i;
   logic          flush_i, flush_busy_o, flush_done_o;
   logic          btb_w_v_o, btb_w_inv_o, btb_r_v_o;
   logic [IW-1:0] btb_idx_w_o, btb_idx_r_o;
   logic [AW-1:0] btb_tgt_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bp_fe_btb_ctrl #(.btb_idx_width_p(IW), .eaddr_width_p(AW)) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .upd_v_i      (upd_v_i),
      .upd_ready_o  (upd_ready_o),
      .upd_idx_i    (upd_idx_i),
      .upd_tgt_i    (upd_tgt_i),
      .lkp_v_i      (lkp_v_i),
      .lkp_ready_o  (lkp_ready_o),
      .lkp_idx_i    (lkp_idx_i),
      .lkp_hazard_o (lkp_hazard_o),
      .flush_i      (flush_i),
      .flush_busy_o (flush_busy_o),
      .flush_done_o (flush_done_o),
      .btb_w_v_o    (btb_w_v_o),
      .btb_w_inv_o  (btb_w_inv_o),
      .btb_idx_w_o  (btb_idx_w_o),
      .btb_tgt_o    (btb_tgt_o),
      .btb_r_v_o    (btb_r_v_o),
      .btb_idx_r_o  (btb_idx_r_o)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      upd_v_i   = 1'b0;
      upd_idx_i = '0;
      upd_tgt_i = '0;
      lkp_v_i   = 1'b0;
      lkp_idx_i = '0;
      flush_i   = 1'b0;
   endtask

   task automatic upd(input logic [IW-1:0] idx, input logic [AW-1:0] tgt);
      upd_v_i   = 1'b1;
      upd_idx_i = idx;
      upd_tgt_i = tgt;
   endtask

   task automatic chk_wr(input string tag, input logic v, input logic inv,
                         input logic [IW-1:0] idx, input logic [AW-1:0] tgt);
      check({tag, ".w_v"}, btb_w_v_o, v);
      check({tag, ".inv"}, btb_w_inv_o, inv);
      check({tag, ".idx"}, btb_idx_w_o, idx);
      check({tag, ".tgt"}, btb_tgt_o, tgt);
   endtask

   initial begin
      reset_i = 1'b1;
      clr_in();
      lkp_v_i = 1'b1;
      #3;
      check("rst.upd_ready", upd_ready_o, 1'b0);
      check("rst.busy", flush_busy_o, 1'b0);
      check("rst.done", flush_done_o, 1'b0);
      check("rst.hazard", lkp_hazard_o, 1'b0);
      chk_wr("rst", 1'b0, 1'b0, 3'd0, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      clr_in();

      // Single update: written in the following cycle.
      upd(3'd5, 64'h1000);
      #1;
      check("u1.ready", upd_ready_o, 1'b1);
      check("u1.w_v_c0", btb_w_v_o, 1'b0);
      tick();
      clr_in();
      lkp_v_i = 1'b1; lkp_idx_i = 3'd5;
      #1;
      chk_wr("u1.c1", 1'b1, 1'b0, 3'd5, 64'h1000);
      check("u1.haz_deq", lkp_hazard_o, 1'b1);
      tick();
      #1;
      check("u1.w_v_c2", btb_w_v_o, 1'b0);
      check("u1.haz_c2", lkp_hazard_o, 1'b0);

      // Lookup hazard on a pending index, none on another index.
      clr_in();
      upd(3'd2, 64'h2222);
      lkp_v_i = 1'b1; lkp_idx_i = 3'd2;
      #1;
      check("hz.c0", lkp_hazard_o, 1'b0);
      tick();
      clr_in();
      lkp_v_i = 1'b1; lkp_idx_i = 3'd2;
      #1;
      check("hz.idx2", lkp_hazard_o, 1'b1);
      lkp_idx_i = 3'd3;
      #1;
      check("hz.idx3", lkp_hazard_o, 1'b0);
      check("hz.r_v", btb_r_v_o, 1'b1);
      check("hz.r_idx", btb_idx_r_o, 3'd3);
      tick();
      clr_in();

      // Back-to-back updates: IDLE drains one per cycle, so ready stays up.
      upd(3'd1, 64'hA);
      #1;
      check("b2b.rdy0", upd_ready_o, 1'b1);
      check("b2b.w0", btb_w_v_o, 1'b0);
      tick();
      upd(3'd4, 64'hB);
      #1;
      check("b2b.rdy1", upd_ready_o, 1'b1);
      chk_wr("b2b.w1", 1'b1, 1'b0, 3'd1, 64'hA);
      tick();
      upd(3'd7, 64'hC);
      #1;
      check("b2b.rdy2", upd_ready_o, 1'b1);
      chk_wr("b2b.w2", 1'b1, 1'b0, 3'd4, 64'hB);
      tick();
      clr_in();
      #1;
      chk_wr("b2b.w3", 1'b1, 1'b0, 3'd7, 64'hC);
      tick();
      #1;
      check("b2b.w4", btb_w_v_o, 1'b0);

`ifdef BP_FE_BTB_CTRL_FLUSH_EN
      // Flush from IDLE with an empty FIFO.
      flush_i = 1'b1;
      #1;
      check("fl.busy0", flush_busy_o, 1'b0);
      tick();
      clr_in();
      lkp_v_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk_wr($sformatf("fl.k%0d", k), 1'b1, 1'b1, k[IW-1:0], 64'h0);
         check($sformatf("fl.lrdy%0d", k), lkp_ready_o, 1'b0);
         check($sformatf("fl.rv%0d", k), btb_r_v_o, 1'b0);
         check($sformatf("fl.busy%0d", k), flush_busy_o, 1'b1);
         check($sformatf("fl.done%0d", k), flush_done_o, 1'b0);
         tick();
      end
      #1;
      check("fl.done", flush_done_o, 1'b1);
      check("fl.busy_end", flush_busy_o, 1'b0);
      check("fl.w_v_end", btb_w_v_o, 1'b0);
      check("fl.lrdy_end", lkp_ready_o, 1'b1);
      tick();
      #1;
      check("fl.done_once", flush_done_o, 1'b0);
      clr_in();

      // Flush with a pending entry plus an update accepted in the same cycle.
      upd(3'd6, 64'h66);
      tick();
      upd(3'd3, 64'h33);
      flush_i = 1'b1;
      #1;
      check("dr.rdy", upd_ready_o, 1'b1);
      chk_wr("dr.c1", 1'b1, 1'b0, 3'd6, 64'h66);
      tick();
      clr_in();
      lkp_v_i = 1'b1; lkp_idx_i = 3'd3;
      #1;
      check("dr.busy", flush_busy_o, 1'b1);
      check("dr.rdy_drain", upd_ready_o, 1'b0);
      check("dr.lrdy", lkp_ready_o, 1'b1);
      check("dr.haz", lkp_hazard_o, 1'b1);
      chk_wr("dr.c2", 1'b1, 1'b0, 3'd3, 64'h33);
      tick();
      clr_in();
      for (int k = 0; k < 8; k++) begin
         flush_i = (k == 2 || k == 7);
         #1;
         chk_wr($sformatf("dr.k%0d", k), 1'b1, 1'b1, k[IW-1:0], 64'h0);
         tick();
      end
      flush_i = 1'b0;
      #1;
      check("dr.done", flush_done_o, 1'b1);
      check("dr.idle", flush_busy_o, 1'b0);
      tick();
      #1;
      check("dr.no_requeue", flush_busy_o, 1'b0);
      check("dr.no_requeue_w", btb_w_v_o, 1'b0);

      // Reset while the flush counter is at 4.
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      repeat (4) tick();
      #1;
      chk_wr("ra.k4", 1'b1, 1'b1, 3'd4, 64'h0);
      reset_i = 1'b1;
      #1;
      check("ra.w_v", btb_w_v_o, 1'b0);
      check("ra.busy", flush_busy_o, 1'b0);
      check("ra.lrdy", lkp_ready_o, 1'b1);
      check("ra.urdy", upd_ready_o, 1'b0);
      tick();
      reset_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("ra.nodone%0d", k), flush_done_o, 1'b0);
         check($sformatf("ra.idle%0d", k), flush_busy_o, 1'b0);
         tick();
      end
`else
      // Without the flush feature, flush_i has no effect.
      upd(3'd6, 64'h66);
      flush_i = 1'b1;
      #1;
      check("nf.rdy", upd_ready_o, 1'b1);
      tick();
      clr_in();
      flush_i = 1'b1;
      lkp_v_i = 1'b1;
      #1;
      chk_wr("nf.w", 1'b1, 1'b0, 3'd6, 64'h66);
      check("nf.busy", flush_busy_o, 1'b0);
      check("nf.lrdy", lkp_ready_o, 1'b1);
      tick();
      #1;
      check("nf.w_v", btb_w_v_o, 1'b0);
      check("nf.inv", btb_w_inv_o, 1'b0);
      check("nf.done", flush_done_o, 1'b0);
      check("nf.urdy", upd_ready_o, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
